subr8u_serial: RTL and testbench

// - Sequential unsigned subtractor; the inverse of our 8-bit unsigned adders: D = A - B, borrow out.
// - Iterative ripple-borrow datapath processes BITS_PER_CYCLE LSBs per clock, trading latency for area.
// - A mod-3 residue checker flags datapath faults at the result.
// - Sits behind the adder netlists in the fault-resilience evaluation harness.

---
 rtl/subr8u_serial.sv | 179 +++++++++++++++++
 tb/tb_subr8u_serial.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/subr8u_serial.sv
// subr8u_serial - iterative unsigned subtractor with a mod-3 residue check.
//
// Computes D = A - B with a borrow out, resolving BITS_PER_CYCLE bits per
// clock LSB first through a ripple-borrow chain. Weighted mod-3 residues of
// A, B and D are built up alongside the bits, and the final identity
// A + borrow*2^WIDTH == B + D (mod 3) is checked when the result is written.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid (sampled only in IDLE)
//   in_ready   block can accept operands (IDLE)
//   a, b       minuend / subtrahend, unsigned, WIDTH bits
//   out_valid  result valid (DONE)
//   out_ready  consumer takes result
//   d          difference (A - B) mod 2^WIDTH
//   borrow     1 iff A < B
//   err        residue mismatch, qualified by out_valid
module subr8u_serial #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             err
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // 2^WIDTH mod 3
  localparam logic [1:0] POW_MOD3 = ((WIDTH % 2) == 1) ? 2'd2 : 2'd1;
  // With an odd slice size the parity of the first bit in a slice follows
  // the counter; with an even slice size every slice starts on an even bit.
  localparam bit BPC_ODD = (BITS_PER_CYCLE % 2) == 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg;
  logic [WIDTH-1:0]    a_sh_reg, b_sh_reg, dw_reg;
  logic                br_reg;
  logic [1:0]          ra_reg, rb_reg, rd_reg;
  logic [WIDTH-1:0]    d_reg;
  logic                borrow_reg, err_reg;

  logic                last_c;
  logic                cnt_par;
  logic [BITS_PER_CYCLE-1:0] dbits_c;
  logic                br_c;
  logic [1:0]          ra_c, rb_c, rd_c;
  logic [1:0]          lhs_c, rhs_c;
  logic                mismatch_c;
  logic [WIDTH-1:0]    dw_next;

  function automatic logic [1:0] add_mod3(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign last_c  = (cnt_reg == CW'(N - 1));
  assign cnt_par = BPC_ODD & cnt_reg[0];

  // One slice of the ripple-borrow chain plus the residue accumulation.
  always_comb begin
    logic       odd;
    logic [1:0] wt;
    br_c    = br_reg;
    ra_c    = ra_reg;
    rb_c    = rb_reg;
    rd_c    = rd_reg;
    dbits_c = '0;
    odd     = 1'b0;
    wt      = 2'd1;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      odd        = cnt_par ^ ((j % 2) == 1);
      wt         = odd ? 2'd2 : 2'd1;
      dbits_c[j] = a_sh_reg[j] ^ b_sh_reg[j] ^ br_c;
      br_c       = (~a_sh_reg[j] & b_sh_reg[j]) | (~(a_sh_reg[j] ^ b_sh_reg[j]) & br_c);
      if (a_sh_reg[j]) ra_c = add_mod3(ra_c, wt);
      if (b_sh_reg[j]) rb_c = add_mod3(rb_c, wt);
      if (dbits_c[j])  rd_c = add_mod3(rd_c, wt);
    end
    lhs_c      = add_mod3(ra_c, br_c ? POW_MOD3 : 2'd0);
    rhs_c      = add_mod3(rb_c, rd_c);
    mismatch_c = (lhs_c != rhs_c);
  end

  // Result bits enter at the top and walk down, so after N slices the
  // first-resolved bits sit at the LSB end.
  assign dw_next = (dw_reg >> BITS_PER_CYCLE) |
                   (WIDTH'(dbits_c) << (WIDTH - BITS_PER_CYCLE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_c)    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  assign d      = d_reg;
  assign borrow = borrow_reg;
  assign err    = err_reg;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      dw_reg     <= '0;
      br_reg     <= 1'b0;
      ra_reg     <= 2'd0;
      rb_reg     <= 2'd0;
      rd_reg     <= 2'd0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg <= a;
            b_sh_reg <= b;
            dw_reg   <= '0;
            br_reg   <= 1'b0;
            ra_reg   <= 2'd0;
            rb_reg   <= 2'd0;
            rd_reg   <= 2'd0;
            cnt_reg  <= '0;
          end
        end
        RUN: begin
          a_sh_reg <= a_sh_reg >> BITS_PER_CYCLE;
          b_sh_reg <= b_sh_reg >> BITS_PER_CYCLE;
          dw_reg   <= dw_next;
          br_reg   <= br_c;
          ra_reg   <= ra_c;
          rb_reg   <= rb_c;
          rd_reg   <= rd_c;
          if (last_c) begin
            d_reg      <= dw_next;
            borrow_reg <= br_c;
            err_reg    <= mismatch_c;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subr8u_serial.sv
module tb_subr8u_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance, BITS_PER_CYCLE = 1
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a_i = 8'd0, b_i = 8'd0;
  logic       in_ready, out_valid, borrow, err;
  logic [7:0] d;

  subr8u_serial #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .borrow(borrow), .err(err));

  // Wider-slice instances, driven in lockstep
  logic       x_valid = 1'b0, x_ready = 1'b0;
  logic [7:0] x_a = 8'd0, x_b = 8'd0;
  logic       r2, v2, br2, e2, r8, v8, br8, e8;
  logic [7:0] d2, d8;

  subr8u_serial #(.WIDTH(8), .BITS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r2),
    .a(x_a), .b(x_b), .out_valid(v2), .out_ready(x_ready),
    .d(d2), .borrow(br2), .err(e2));

  subr8u_serial #(.WIDTH(8), .BITS_PER_CYCLE(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r8),
    .a(x_a), .b(x_b), .out_valid(v8), .out_ready(x_ready),
    .d(d8), .borrow(br8), .err(e8));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
  } vec_t;

  vec_t vecs[10];

  // Present operands in IDLE, then count edges until out_valid is seen.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a_i = ta; b_i = tb;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " idle out_valid"}, out_valid, 0);
    check({name, " idle in_ready"}, in_ready, 1);
  endtask

  initial begin
    int lat, l2, l8, cyc;
    logic [7:0] hd;
    logic hb, he;
    logic [8:0] exp9;
    logic [7:0] sa, sb;

    vecs[0] = '{8'd200, 8'd55,  8'h91, 1'b0};
    vecs[1] = '{8'd55,  8'd200, 8'h6F, 1'b1};
    vecs[2] = '{8'h00,  8'h01,  8'hFF, 1'b1};
    vecs[3] = '{8'hFF,  8'hFF,  8'h00, 1'b0};
    vecs[4] = '{8'd10,  8'd3,   8'h07, 1'b0};
    vecs[5] = '{8'h00,  8'h00,  8'h00, 1'b0};
    vecs[6] = '{8'h80,  8'h01,  8'h7F, 1'b0};
    vecs[7] = '{8'hFF,  8'h00,  8'hFF, 1'b0};
    vecs[8] = '{8'h00,  8'hFF,  8'h01, 1'b1};
    vecs[9] = '{8'hA5,  8'h5A,  8'h4B, 1'b0};

    // Reset state
    #2;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst d", d, 0);
    check("rst borrow", borrow, 0);
    check("rst err", err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      $display("op %0d: a=%0d b=%0d -> d=0x%02h borrow=%0b err=%0b lat=%0d",
               i, vecs[i].a, vecs[i].b, d, borrow, err, lat);
      check($sformatf("v%0d latency", i), lat, 8);
      check($sformatf("v%0d d", i), d, vecs[i].d);
      check($sformatf("v%0d borrow", i), borrow, vecs[i].br);
      check($sformatf("v%0d err", i), err, 0);
      check($sformatf("v%0d in_ready", i), in_ready, 0);
      drain($sformatf("v%0d", i));
    end

    // Backpressure: result held for 5 cycles, new operands in DONE ignored
    run_op(8'd200, 8'd55, lat);
    hd = d; hb = borrow; he = err;
    check("bp d", hd, 8'h91);
    in_valid = 1'b1; a_i = 8'd1; b_i = 8'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp d stable", d, hd);
      check("bp borrow stable", borrow, hb);
      check("bp err stable", err, he);
    end
    in_valid = 1'b0;
    drain("bp");
    $display("backpressure: held d=0x%02h for 5 cycles", hd);

    // Operands changing during RUN are ignored
    @(negedge clk);
    in_valid = 1'b1; a_i = 8'd55; b_i = 8'd200;
    @(negedge clk);
    a_i = 8'd0; b_i = 8'd1;
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    in_valid = 1'b0;
    check("runignore latency", cyc, 8);
    check("runignore d", d, 8'h6F);
    check("runignore borrow", borrow, 1);
    $display("run-ignore: d=0x%02h borrow=%0b", d, borrow);
    drain("runignore");

    // Reset mid-RUN (RUN cycle 3)
    @(negedge clk);
    in_valid = 1'b1; a_i = 8'd200; b_i = 8'd55;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd10, 8'd3, lat);
    check("postrst latency", lat, 8);
    check("postrst d", d, 8'h07);
    check("postrst borrow", borrow, 0);
    $display("reset mid-run then a=10 b=3 -> d=%0d", d);
    drain("postrst");

    // Fault injection: borrow chain forced to 1 before the first slice
    @(negedge clk);
    in_valid = 1'b1; a_i = 8'h80; b_i = 8'h01;
    @(negedge clk);
    in_valid = 1'b0;
    force dut.br_reg = 1'b1;
    @(negedge clk);
    release dut.br_reg;
    cyc = 1;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check("fault out_valid", out_valid, 1);
    check("fault err", err, 1);
    check("fault d", d, 8'h7E);
    $display("fault inject: d=0x%02h err=%0b", d, err);
    drain("fault");

    // BITS_PER_CYCLE = 2 and 8, 4096 spread pairs incl. corner values
    for (int i = 0; i < 4096; i++) begin
      sa = 8'(i);
      sb = 8'((i >> 4) * 13 + i * 7);
      if (i == 4095) begin sa = 8'h00; sb = 8'hFF; end
      exp9 = {1'b0, sa} - {1'b0, sb};
      @(negedge clk);
      x_valid = 1'b1; x_a = sa; x_b = sb;
      @(negedge clk);
      x_valid = 1'b0;
      l2 = 0; l8 = 0;
      if (v8) l8 = 1;
      cyc = 0;
      while (!(v2 && v8) && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (v2 && l2 == 0) l2 = cyc;
        if (v8 && l8 == 0) l8 = cyc;
      end
      if (i < 4) begin
        check("bpc2 latency", l2, 4);
        check("bpc8 latency", l8, 1);
      end
      check($sformatf("bpc2 a=%0d b=%0d", sa, sb), {e2, br2, d2}, {1'b0, exp9});
      check($sformatf("bpc8 a=%0d b=%0d", sa, sb), {e8, br8, d8}, {1'b0, exp9});
      if (i % 512 == 0)
        $display("wide pair %0d: a=%0d b=%0d bpc2={%0b,0x%02h} bpc8={%0b,0x%02h}",
                 i, sa, sb, br2, d2, br8, d8);
      x_ready = 1'b1;
      @(negedge clk);
      x_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
